// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified memory port arbiter and the pipeline memory model.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2,
      ARB_RESP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of consecutive data grants taken while a fetch is waiting.
module arb_starve_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         at_limit
);

   assign at_limit = (cnt == limit);

   // Clear wins over increment; increment stops at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage.
// Data wins arbitration unless fetch has been passed over MAX_DGRANT times in a row.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MAX_DGRANT = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IF_Req,
   input  logic [ADDR_W-1:0] IF_Addr,
   output logic              IF_Valid,
   output logic [DATA_W-1:0] IF_Rdata,
   output logic              IF_Stall,
   input  logic              D_Req,
   input  logic              D_We,
   input  logic [ADDR_W-1:0] D_Addr,
   input  logic [DATA_W-1:0] D_Wdata,
   output logic              D_Valid,
   output logic [DATA_W-1:0] D_Rdata,
   output logic              D_Stall,
   output logic              Mem_Req,
   output logic              Mem_We,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_Wdata,
   input  logic              Mem_Ack,
   input  logic [DATA_W-1:0] Mem_Rdata,
   output logic              Busy
);

   arb_state_t        state, state_d;
   logic              mem_req_d, mem_we_d, if_valid_d, d_valid_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;
   logic              cnt_inc, cnt_clear, at_limit;
   logic [CNT_W-1:0]  starve_cnt;

   arb_starve_cnt #(.W(CNT_W)) u_starve_cnt (
      .clk      (CLK),
      .rst      (RESET),
      .inc      (cnt_inc),
      .clear    (cnt_clear),
      .limit    (CNT_W'(MAX_DGRANT)),
      .cnt      (starve_cnt),
      .at_limit (at_limit)
   );

   assign IF_Stall = IF_Req && !IF_Valid;
   assign D_Stall  = D_Req && !D_Valid;

   // Next state and next values of every registered output.
   always_comb begin
      state_d     = state;
      mem_req_d   = Mem_Req;
      mem_we_d    = Mem_We;
      mem_addr_d  = Mem_Addr;
      mem_wdata_d = Mem_Wdata;
      if_valid_d  = 1'b0;
      if_rdata_d  = IF_Rdata;
      d_valid_d   = 1'b0;
      d_rdata_d   = D_Rdata;
      cnt_inc     = 1'b0;
      cnt_clear   = 1'b0;
      case (state)
         ARB_IDLE: begin
            cnt_clear = !IF_Req;
            if (D_Req && !(IF_Req && at_limit)) begin
               state_d     = ARB_BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = D_We;
               mem_addr_d  = D_Addr;
               mem_wdata_d = D_Wdata;
               cnt_inc     = IF_Req;
            end else if (IF_Req) begin
               state_d     = ARB_BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = IF_Addr;
               mem_wdata_d = '0;
               cnt_clear   = 1'b1;
            end
         end
         ARB_BUSY_I: begin
            if (Mem_Ack) begin
               state_d    = ARB_RESP;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               if_valid_d = 1'b1;
               if_rdata_d = Mem_Rdata;
            end
         end
         ARB_BUSY_D: begin
            if (Mem_Ack) begin
               state_d   = ARB_RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               d_valid_d = 1'b1;
               // Stores leave the last load result untouched.
               if (!Mem_We) begin
                  d_rdata_d = Mem_Rdata;
               end
            end
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ARB_IDLE;
         Mem_Req   <= 1'b0;
         Mem_We    <= 1'b0;
         Mem_Addr  <= '0;
         Mem_Wdata <= '0;
         IF_Valid  <= 1'b0;
         IF_Rdata  <= '0;
         D_Valid   <= 1'b0;
         D_Rdata   <= '0;
         Busy      <= 1'b0;
      end else begin
         state     <= state_d;
         Mem_Req   <= mem_req_d;
         Mem_We    <= mem_we_d;
         Mem_Addr  <= mem_addr_d;
         Mem_Wdata <= mem_wdata_d;
         IF_Valid  <= if_valid_d;
         IF_Rdata  <= if_rdata_d;
         D_Valid   <= d_valid_d;
         D_Rdata   <= d_rdata_d;
         Busy      <= (state_d != ARB_IDLE);
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Sequences every access through a request/ack handshake to a variable-latency memory.
- Returns read data to the requester and generates per-port stall signals. These stalls are ORed with hazard-unit stalls into PCWrite/IFIDWrite.
- Data port has priority. A bounded-starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DGRANT, 4, consecutive data grants allowed while IF_Req is pending before IF is forced to win (range 1..15)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
IF_Req  in  1  fetch request; held with IF_Addr stable until IF_Valid
IF_Addr  in  ADDR_W  fetch address (PC)
IF_Valid  out  1  one-cycle pulse: IF_Rdata valid, fetch complete
IF_Rdata  out  DATA_W  fetched instruction
IF_Stall  out  1  IF_Req && !IF_Valid
D_Req  in  1  data request; held with D_We/D_Addr/D_Wdata stable until D_Valid
D_We  in  1  1 = sw, 0 = lw
D_Addr  in  ADDR_W  data address
D_Wdata  in  DATA_W  store data
D_Valid  out  1  one-cycle pulse: data access complete
D_Rdata  out  DATA_W  load data
D_Stall  out  1  D_Req && !D_Valid
Mem_Req  out  1  memory request, held until Mem_Ack
Mem_We  out  1  memory write enable
Mem_Addr  out  ADDR_W  memory address
Mem_Wdata  out  DATA_W  memory write data
Mem_Ack  in  1  memory completion, one cycle
Mem_Rdata  in  DATA_W  read data, valid with Mem_Ack
Busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high.
- Reset values: state IDLE, starvation count 0, and all outputs 0 (Mem_Req, Mem_We, Mem_Addr, Mem_Wdata, IF_Valid, IF_Rdata, D_Valid, D_Rdata, Busy). IF_Stall and D_Stall follow their equations.
- All outputs except IF_Stall and D_Stall are registered.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration:
  - D_Req only: go to BUSY_D.
  - IF_Req only: go to BUSY_I.
  - Both: go to BUSY_D, unless cnt == MAX_DGRANT, in which case go to BUSY_I.
  - On entry to a BUSY state: Mem_Req=1, and Mem_Addr/Mem_We/Mem_Wdata are latched from the winner. For BUSY_I, Mem_We=0 and Mem_Wdata=0.
- BUSY_x: Mem_Req and its fields stay stable until Mem_Ack.
  - Mem_Ack may arrive in the first BUSY cycle (zero-wait memory).
  - On Mem_Ack: Mem_Req=0, Mem_We=0, go to RESP.
  - BUSY_I: IF_Rdata <= Mem_Rdata, IF_Valid <= 1.
  - BUSY_D read: D_Rdata <= Mem_Rdata, D_Valid <= 1.
  - BUSY_D write: D_Rdata holds its previous value, D_Valid <= 1.
- RESP: exactly one cycle with the Valid pulse, no arbitration, then return to IDLE.
  - The requester must drop or update its Req/operands in the cycle after Valid.
  - Minimum access: 3 cycles (IDLE, BUSY, RESP).
- Starvation counter:
  - +1 on each D grant made while IF_Req=1, saturating at MAX_DGRANT.
  - Cleared on any IF grant, or in IDLE when IF_Req=0.
- Mem_Ack outside BUSY states (stray, or arriving after a reset) is ignored: no Valid, no data update.
- Reset mid-access: the next cycle is IDLE with all outputs 0. The interrupted access is abandoned and never signalled valid.
- Req rising during RESP is evaluated in the following IDLE cycle.
- Stall is combinational: IF_Stall=0 in the IF_Valid cycle, which lets the PC advance.

Decomposition:
- Shared package: arbiter state encoding (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RESP as a 2-bit typedef) and ADDR_W/DATA_W defaults shared with the pipeline memory model.
- One natural sub-module: arb_starve_cnt, a saturating counter with inc, clear, limit and at_limit.

Test Plan:
- IF alone, zero-wait memory: IF_Req=1, IF_Addr=0x40 at cycle 0 (IDLE), Mem_Ack=1 with Mem_Rdata=0x8C220004 at cycle 1 -> Mem_Req=1, Mem_Addr=0x40 at cycle 1; IF_Valid=1, IF_Rdata=0x8C220004 at cycle 2; IDLE at cycle 3; IF_Stall=1 at cycles 0-1.
- Simultaneous requests: IF_Req at 0x44 and D_Req read at 0x100 in the same IDLE cycle, ack in 1 cycle -> D served first (Mem_Addr=0x100, D_Valid), then IF (Mem_Addr=0x44, IF_Valid); D_Stall=0 in the D_Valid cycle.
- Starvation, MAX_DGRANT=2: D_Req continuously high (addresses 0x100, 0x104, 0x108), IF_Req held at 0x48 -> grant order D 0x100, D 0x104, IF 0x48, D 0x108.
- Store: D_Req=1, D_We=1, D_Addr=0x200, D_Wdata=0xDEADBEEF, ack after 2 wait cycles -> Mem_We=1 and Mem_Wdata=0xDEADBEEF for 3 cycles; D_Valid pulses once; D_Rdata unchanged.
- Wait states: IF fetch with Mem_Ack 3 cycles after Mem_Req -> Mem_Req and Mem_Addr stable for 3 cycles; IF_Stall=1 every cycle until IF_Valid; exactly one IF_Valid.
- Reset mid-access: RESET=1 for 1 cycle in BUSY_D, memory asserts Mem_Ack 2 cycles later -> IDLE and all outputs 0 after reset; no D_Valid; stray Mem_Ack ignored; a subsequent request proceeds normally.
